bsg_manycore_sdr_reset_sequencer: RTL and testbench



---
 rtl/bsg_manycore_pkg.sv | 12 +
 rtl/bsg_counter_clear_up.sv | 32 +++
 rtl/bsg_manycore_sdr_reset_sequencer.sv | 125 ++++++++++++
 tb/tb_bsg_manycore_sdr_reset_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/bsg_manycore_pkg.sv
// Types shared between the SDR reset sequencer and the link adapter integrator.
package bsg_manycore_pkg;

   // Per-direction link disables, MSB first in the order the adapter expects.
   typedef struct packed {
      logic rev_o;
      logic rev_i;
      logic fwd_o;
      logic fwd_i;
   } bsg_manycore_link_disable_s;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous reset and a clear that wins over increment.
module bsg_counter_clear_up
   #(parameter int max_val_p    = 31
    ,parameter int init_val_p   = 0
    ,parameter int ptr_width_lp = $clog2(max_val_p + 1)
   )
   (input  logic                    clk_i
   ,input  logic                    reset_i
   ,input  logic                    clear_i
   ,input  logic                    up_i
   ,output logic [ptr_width_lp-1:0] count_o
   );

   localparam logic [ptr_width_lp-1:0] lp_max  = ptr_width_lp'(max_val_p);
   localparam logic [ptr_width_lp-1:0] lp_init = ptr_width_lp'(init_val_p);

   logic [ptr_width_lp-1:0] r_count;

   always_ff @(posedge clk_i) begin
      if (reset_i)
         r_count <= lp_init;
      else if (clear_i)
         r_count <= {ptr_width_lp{1'b0}};
      else if (up_i)
         r_count <= (r_count == lp_max) ? {ptr_width_lp{1'b0}} : r_count + ptr_width_lp'(1);
      else
         r_count <= r_count;
   end

   assign count_o = r_count;

endmodule

// File: rtl/bsg_manycore_sdr_reset_sequencer.sv
// Ordered reset release for one manycore SDR link edge: token pulse, then
// uplink, downlink and downstream resets drop one gap apart.
module bsg_manycore_sdr_reset_sequencer
   import bsg_manycore_pkg::*;
   #(parameter int gap_cycles_p = 32)
   (input  logic       clk_i
   ,input  logic       reset_i
   ,input  logic       start_i
   ,input  logic [3:0] disable_i
   ,output logic       uplink_reset_o
   ,output logic       downlink_reset_o
   ,output logic       downstream_reset_o
   ,output logic       token_reset_o
   ,output logic [3:0] disable_o
   ,output logic       done_o
   );

   localparam int gap_width_lp = $clog2(gap_cycles_p);
   localparam logic [gap_width_lp-1:0] lp_gap_last = gap_width_lp'(gap_cycles_p - 1);

   typedef enum logic [5:0] {
      S_HOLD       = 6'b000001,
      S_TOKEN      = 6'b000010,
      S_TOKEN_WAIT = 6'b000100,
      S_UPLINK     = 6'b001000,
      S_DOWNLINK   = 6'b010000,
      S_DONE       = 6'b100000
   } state_e;

   state_e                     r_state;
   logic                       r_uplink_reset;
   logic                       r_downlink_reset;
   logic                       r_downstream_reset;
   logic                       r_token_reset;
   logic                       r_done;
   bsg_manycore_link_disable_s r_disable;

   logic [gap_width_lp-1:0] w_count;
   logic                    w_in_done;
   logic                    w_legal;
   logic                    w_advance;

   assign w_in_done = (r_state == S_DONE);
   assign w_legal   = r_state inside {S_HOLD, S_TOKEN, S_TOKEN_WAIT, S_UPLINK, S_DOWNLINK, S_DONE};
   // A corrupted one-hot state forces a transition so it recovers to S_HOLD.
   assign w_advance = ~w_legal | (w_in_done ? start_i : (w_count == lp_gap_last));

   bsg_counter_clear_up
      #(.max_val_p (gap_cycles_p - 1)
       ,.init_val_p(0)
      )
   gap_counter
      (.clk_i  (clk_i)
      ,.reset_i(reset_i)
      ,.clear_i(w_advance)
      ,.up_i   (~w_in_done)
      ,.count_o(w_count)
      );

   // Outputs are loaded with the next state's values so each is a clean flop.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state            <= S_HOLD;
         r_uplink_reset     <= 1'b1;
         r_downlink_reset   <= 1'b1;
         r_downstream_reset <= 1'b1;
         r_token_reset      <= 1'b0;
         r_done             <= 1'b0;
         r_disable          <= disable_i;
      end
      else if (w_advance) begin
         case (r_state)
            S_HOLD: begin
               r_state       <= S_TOKEN;
               r_token_reset <= 1'b1;
            end
            S_TOKEN: begin
               r_state       <= S_TOKEN_WAIT;
               r_token_reset <= 1'b0;
            end
            S_TOKEN_WAIT: begin
               r_state        <= S_UPLINK;
               r_uplink_reset <= 1'b0;
            end
            S_UPLINK: begin
               r_state          <= S_DOWNLINK;
               r_downlink_reset <= 1'b0;
            end
            S_DOWNLINK: begin
               r_state            <= S_DONE;
               r_downstream_reset <= 1'b0;
               r_done             <= 1'b1;
            end
            S_DONE: begin
               r_state            <= S_HOLD;
               r_uplink_reset     <= 1'b1;
               r_downlink_reset   <= 1'b1;
               r_downstream_reset <= 1'b1;
               r_token_reset      <= 1'b0;
               r_done             <= 1'b0;
               r_disable          <= disable_i;
            end
            default: begin
               r_state            <= S_HOLD;
               r_uplink_reset     <= 1'b1;
               r_downlink_reset   <= 1'b1;
               r_downstream_reset <= 1'b1;
               r_token_reset      <= 1'b0;
               r_done             <= 1'b0;
            end
         endcase
      end
      else begin
         r_state <= r_state;
      end
   end

   assign uplink_reset_o     = r_uplink_reset;
   assign downlink_reset_o   = r_downlink_reset;
   assign downstream_reset_o = r_downstream_reset;
   assign token_reset_o      = r_token_reset;
   assign done_o             = r_done;
   assign disable_o          = r_disable;

endmodule

// File: tb/tb_bsg_manycore_sdr_reset_sequencer.sv
// Directed bench for the SDR reset sequencer with a release-schedule scoreboard.
module tb_bsg_manycore_sdr_reset_sequencer;

   localparam int G = 4;

   logic       clk = 1'b0;
   logic       reset_i;
   logic       start_i;
   logic [3:0] disable_i;
   logic       uplink_reset_o;
   logic       downlink_reset_o;
   logic       downstream_reset_o;
   logic       token_reset_o;
   logic [3:0] disable_o;
   logic       done_o;

   typedef struct packed {
      logic       up;
      logic       down;
      logic       ds;
      logic       tok;
      logic       done;
      logic [3:0] dis;
   } obs_t;

   obs_t       q[$];
   int         errors = 0;
   int         checks = 0;
   int         cyc    = 0;
   int         rel    = 0;
   logic [3:0] m_dis  = 4'b0000;

   always #5 clk = ~clk;

   bsg_manycore_sdr_reset_sequencer #(.gap_cycles_p(G)) dut
      (.clk_i             (clk)
      ,.reset_i           (reset_i)
      ,.start_i           (start_i)
      ,.disable_i         (disable_i)
      ,.uplink_reset_o    (uplink_reset_o)
      ,.downlink_reset_o  (downlink_reset_o)
      ,.downstream_reset_o(downstream_reset_o)
      ,.token_reset_o     (token_reset_o)
      ,.disable_o         (disable_o)
      ,.done_o            (done_o)
      );

   // Expected outputs d cycles after the sequence (re)started from S_HOLD.
   function automatic obs_t model(int d, logic [3:0] dis);
      obs_t e;
      e.up   = (d < 3*G);
      e.down = (d < 4*G);
      e.ds   = (d < 5*G);
      e.tok  = (d >= G) && (d < 2*G);
      e.done = (d >= 5*G);
      e.dis  = dis;
      return e;
   endfunction

   function automatic int cur_d();
      return cyc - rel;
   endfunction

   task automatic step(input string tag);
      obs_t e;
      obs_t o;
      if (reset_i) begin
         rel   = cyc + 1;
         m_dis = disable_i;
      end
      else if ((cyc - rel) >= 5*G && start_i) begin
         rel   = cyc + 1;
         m_dis = disable_i;
      end
      q.push_back(model(cyc + 1 - rel, m_dis));
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      o = '{up: uplink_reset_o, down: downlink_reset_o, ds: downstream_reset_o,
            tok: token_reset_o, done: done_o, dis: disable_o};
      e = q.pop_front();
      checks = checks + 1;
      assert (o === e) else begin
         errors = errors + 1;
         $error("FAIL %s cyc=%0d d=%0d observed=%b expected=%b (up,down,ds,tok,done,dis)",
                tag, cyc, cyc - rel, o, e);
      end
   endtask

   initial begin
      reset_i   = 1'b1;
      start_i   = 1'b0;
      disable_i = 4'b0101;
      @(posedge clk);
      #1;
      repeat (3) step("reset");
      reset_i = 1'b0;

      // First run: start_i held mid-sequence must be ignored; disable_i change too.
      while (cur_d() < 25) begin
         start_i   = (cur_d() >= 5 && cur_d() <= 15);
         disable_i = (cur_d() >= 8) ? 4'b1010 : 4'b0101;
         step("seq1");
      end
      start_i = 1'b1;
      step("restart");
      start_i = 1'b0;

      // Second run, interrupted by reset in S_UPLINK.
      while (cur_d() < 14) step("seq2");
      reset_i   = 1'b1;
      disable_i = 4'b1100;
      step("midreset");
      reset_i   = 1'b0;
      repeat (5*G + 3) step("seq3");

      // Reset and start together in S_DONE: reset wins.
      reset_i   = 1'b1;
      start_i   = 1'b1;
      disable_i = 4'b0110;
      step("rst_start");
      reset_i = 1'b0;
      start_i = 1'b0;
      repeat (5*G + 2) step("seq4");

      // Plain restart picks up a new disable vector.
      disable_i = 4'b0011;
      start_i   = 1'b1;
      step("restart2");
      start_i   = 1'b0;
      disable_i = 4'b1111;
      repeat (5*G + 2) step("seq5");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
